traffic_light_ctrl: RTL

TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

---
 rtl/traffic_light_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/traffic_light_ctrl.sv
// Round-robin traffic light controller: GREEN -> YELLOW -> ALLRED per approach,
// with a hold input that extends green and a flashing-yellow night mode.
module traffic_light_ctrl #(
    parameter int N_DIR      = 4,
    parameter int T_GREEN    = 8,
    parameter int T_YELLOW   = 3,
    parameter int T_ALLRED   = 2,
    parameter int FLASH_HALF = 4,
    parameter int CNT_W      = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       hold,
    input  logic                       flash,
    output logic [3*N_DIR-1:0]         light,
    output logic [$clog2(N_DIR)-1:0]   active_dir,
    output logic [1:0]                 phase
);

    localparam int DW = $clog2(N_DIR);

    localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(T_GREEN - 1);
    localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'(T_ALLRED - 1);
    localparam logic [CNT_W-1:0] LD_FLASH  = CNT_W'(FLASH_HALF - 1);
    localparam logic [DW-1:0]    LAST_DIR  = DW'(N_DIR - 1);

    localparam logic [2:0] LAMP_RED    = 3'b001;
    localparam logic [2:0] LAMP_GREEN  = 3'b010;
    localparam logic [2:0] LAMP_YELLOW = 3'b100;
    localparam logic [2:0] LAMP_DARK   = 3'b000;

    typedef enum logic [1:0] {
        PH_GREEN  = 2'b00,
        PH_YELLOW = 2'b01,
        PH_ALLRED = 2'b10,
        PH_FLASH  = 2'b11
    } phase_t;

    phase_t           phase_q, phase_nx;
    logic [DW-1:0]    dir_nx;
    logic [CNT_W-1:0] timer_q, timer_nx;
    logic             blink_q, blink_nx;
    logic             dir_bad;

    // An out-of-range direction index (non-power-of-two N_DIR) is treated as corrupt state.
    assign dir_bad = (active_dir > LAST_DIR);
    assign phase   = phase_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q    <= PH_GREEN;
            active_dir <= '0;
            timer_q    <= LD_GREEN;
            blink_q    <= 1'b1;
        end else begin
            phase_q    <= phase_nx;
            active_dir <= dir_nx;
            timer_q    <= timer_nx;
            blink_q    <= blink_nx;
        end
    end

    always_comb begin
        phase_nx = phase_q;
        dir_nx   = active_dir;
        timer_nx = timer_q - CNT_W'(1);
        blink_nx = blink_q;
        if (dir_bad) begin
            phase_nx = PH_ALLRED;
            dir_nx   = LAST_DIR;
            timer_nx = LD_ALLRED;
        end else begin
            case (phase_q)
                PH_GREEN: begin
                    if (flash || (!hold && timer_q == '0)) begin
                        phase_nx = PH_YELLOW;
                        timer_nx = LD_YELLOW;
                    end else if (hold) begin
                        timer_nx = timer_q;
                    end
                end
                PH_YELLOW: begin
                    if (timer_q == '0) begin
                        phase_nx = PH_ALLRED;
                        timer_nx = LD_ALLRED;
                    end
                end
                PH_ALLRED: begin
                    if (timer_q == '0) begin
                        if (flash) begin
                            phase_nx = PH_FLASH;
                            timer_nx = LD_FLASH;
                            blink_nx = 1'b1;
                        end else begin
                            phase_nx = PH_GREEN;
                            timer_nx = LD_GREEN;
                            dir_nx   = (active_dir == LAST_DIR) ? '0 : active_dir + DW'(1);
                        end
                    end
                end
                PH_FLASH: begin
                    // Parking on the last index makes the next ALLRED expiry wrap to approach 0.
                    if (!flash) begin
                        phase_nx = PH_ALLRED;
                        timer_nx = LD_ALLRED;
                        dir_nx   = LAST_DIR;
                    end else if (timer_q == '0) begin
                        timer_nx = LD_FLASH;
                        blink_nx = ~blink_q;
                    end
                end
                default: begin
                    phase_nx = PH_ALLRED;
                    timer_nx = LD_ALLRED;
                end
            endcase
        end
    end

    always_comb begin
        light = '0;
        for (int i = 0; i < N_DIR; i++) begin
            case (phase_q)
                PH_GREEN:  light[3*i +: 3] = (!dir_bad && active_dir == DW'(i)) ? LAMP_GREEN  : LAMP_RED;
                PH_YELLOW: light[3*i +: 3] = (!dir_bad && active_dir == DW'(i)) ? LAMP_YELLOW : LAMP_RED;
                PH_FLASH:  light[3*i +: 3] = blink_q ? LAMP_YELLOW : LAMP_DARK;
                default:   light[3*i +: 3] = LAMP_RED;
            endcase
        end
    end

endmodule
